// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result buses of the serial subtractor.
// Latency: none, signal bundle only.
// Backpressure: none; the requester sees busy and holds off, start during busy is dropped by the slave.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] di;
    logic             bo;
    logic             ov;

    modport master (
        output start, a, b, bin,
        input  busy, done, di, bo, ov
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, di, bo, ov
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: di = a - b - bin over WIDTH bits, one bit per clock LSB first, one full-subtractor cell.
// Latency: WIDTH+1 cycles from accepted start to the one-cycle done pulse; one op per WIDTH+1 cycles.
// Backpressure: start honoured only in IDLE/DONE; start during RUN is dropped, never queued.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    // Operand sign bits are kept aside because the shift registers lose them.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] di_q, di_d;
    logic             bo_q, bo_d;
    logic             ov_q, ov_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             x_bit, y_bit, d_bit, brw_nxt;
    logic [WIDTH-1:0] res_nxt;

    // Full-subtractor cell on the current operand LSBs; result enters from the MSB end
    always_comb begin
        x_bit   = a_sr_q[0];
        y_bit   = b_sr_q[0];
        d_bit   = x_bit ^ y_bit ^ brw_q;
        brw_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & brw_q);
        res_nxt = {d_bit, res_q[WIDTH-1:1]};
    end

    // Next-state logic: accept in IDLE/DONE, shift one bit per cycle in RUN, publish on the last bit
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        di_d    = di_q;
        bo_d    = bo_q;
        ov_d    = ov_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                brw_d  = brw_nxt;
                res_d  = res_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    di_d    = res_nxt;
                    bo_d    = brw_nxt;
                    ov_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_nxt[WIDTH-1]);
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    brw_d   = bus.bin;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State registers; reset wins over any start in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            di_q    <= '0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            di_q    <= di_d;
            bo_q    <= bo_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.di   = di_q;
    assign bus.bo   = bo_q;
    assign bus.ov   = ov_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at WIDTH 2, 8 and 16.
// Latency: result expected WIDTH+1 samples after the accepting edge.
// Backpressure: stimulus waits for done before issuing the next start.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(2))  bus2 ();
    serial_subtractor_if #(.WIDTH(8))  bus8 ();
    serial_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_subtractor #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ov, bo, di[15:0]}
    function automatic logic [17:0] ref_sub(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic bin);
        longint p, lim, ua, ub, diff, sa, sb, sd;
        logic [15:0] di;
        logic        bo, ov;
        p    = longint'(1) << w;
        lim  = p / 2;
        ua   = longint'(a);
        ub   = longint'(b);
        diff = ua - ub - longint'(bin);
        bo   = (diff < 0);
        di   = 16'((diff + p) % p);
        sa   = (ua >= lim) ? ua - p : ua;
        sb   = (ub >= lim) ? ub - p : ub;
        sd   = sa - sb - longint'(bin);
        ov   = (sd < -lim) || (sd >= lim);
        return {ov, bo, di};
    endfunction

    // Present operands and start immediately, hold start across one rising edge
    task automatic kick8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge clk);
        kick8(a, b, bin);
    endtask

    // Wait for done, scrambling inputs meanwhile; optional start pulse at sample pulse_at
    task automatic finish8(input string tag, input logic [7:0] edi, input logic ebo,
                           input logic eov, input int pulse_at);
        int lat   = 0;
        int nbusy = 0;
        int novl  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus8.busy) nbusy++;
            if (bus8.busy && bus8.done) novl++;
            if (!bus8.done) begin
                bus8.a   = 8'($urandom);
                bus8.b   = 8'($urandom);
                bus8.bin = 1'($urandom);
            end
            bus8.start = (lat == pulse_at);
        end while (!bus8.done && lat < 40);
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_busy_cycles"}, nbusy, 8);
        chk({tag, "_busy_done_overlap"}, novl, 0);
        chk({tag, "_di"}, 32'(bus8.di), 32'(edi));
        chk({tag, "_bo"}, 32'(bus8.bo), 32'(ebo));
        chk({tag, "_ov"}, 32'(bus8.ov), 32'(eov));
    endtask

    // Count done pulses over n idle cycles
    task automatic quiet8(input string tag, input int n);
        int nd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus8.done) nd++;
        end
        chk({tag, "_spurious_done"}, nd, 0);
    endtask

    initial begin
        logic [17:0] e;
        logic [15:0] ra, rb;
        logic        rbin;
        logic [4:0]  sel2;

        rst = 1'b1;
        bus2.start = 1'b0;  bus2.a = '0;  bus2.b = '0;  bus2.bin = 1'b0;
        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.bin = 1'b0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus8.busy), 0);
        chk("rst_done", 32'(bus8.done), 0);
        chk("rst_di", 32'(bus8.di), 0);
        chk("rst_bo", 32'(bus8.bo), 0);
        chk("rst_ov", 32'(bus8.ov), 0);
        chk("rst_w16", 32'({bus16.busy, bus16.done, bus16.ov, bus16.bo, bus16.di}), 0);
        rst = 1'b0;

        // Directed cases
        launch8(8'h05, 8'h03, 1'b0); finish8("d05m03", 8'h02, 1'b0, 1'b0, 0);
        launch8(8'h03, 8'h05, 1'b0); finish8("d03m05", 8'hFE, 1'b1, 1'b0, 0);
        launch8(8'h80, 8'h01, 1'b0); finish8("d80m01", 8'h7F, 1'b0, 1'b1, 0);
        launch8(8'h7F, 8'hFF, 1'b0); finish8("d7Fm FF", 8'h80, 1'b1, 1'b1, 0);
        launch8(8'hFF, 8'hFF, 1'b0); finish8("dFFmFF", 8'h00, 1'b0, 1'b0, 0);
        launch8(8'h00, 8'h00, 1'b1); finish8("d00m00b", 8'hFF, 1'b1, 1'b0, 0);

        // Start pulsed mid-RUN with other operands: ignored, one done only
        launch8(8'h9C, 8'h21, 1'b1); finish8("midstart", 8'h7A, 1'b0, 1'b1, 3);
        quiet8("midstart", 12);

        // Back-to-back: start held on the done cycle
        launch8(8'h10, 8'h01, 1'b0); finish8("b2b_first", 8'h0F, 1'b0, 1'b0, 0);
        kick8(8'h01, 8'h02, 1'b1);   finish8("b2b_second", 8'hFE, 1'b1, 1'b0, 0);

        // Reset during RUN cycle 4 clears everything and suppresses done
        launch8(8'h5A, 8'h33, 1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(bus8.busy), 0);
        chk("midrst_done", 32'(bus8.done), 0);
        chk("midrst_di", 32'(bus8.di), 0);
        chk("midrst_bo", 32'(bus8.bo), 0);
        chk("midrst_ov", 32'(bus8.ov), 0);
        rst = 1'b0;
        quiet8("midrst", 14);

        // Reset has priority over start in the same cycle
        @(negedge clk);
        rst = 1'b1;
        bus8.a = 8'h44; bus8.b = 8'h11; bus8.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus8.start = 1'b0;
        @(negedge clk);
        chk("rst_vs_start_busy", 32'(bus8.busy), 0);
        quiet8("rst_vs_start", 12);

        // Random WIDTH=8 against the reference
        for (int n = 0; n < 30; n++) begin
            ra   = 16'($urandom_range(0, 255));
            rb   = 16'($urandom_range(0, 255));
            rbin = 1'($urandom);
            e    = ref_sub(8, ra, rb, rbin);
            launch8(ra[7:0], rb[7:0], rbin);
            finish8("rnd8", e[7:0], e[16], e[17], 0);
        end

        // WIDTH=2 exhaustive and WIDTH=16 random, run side by side
        for (int n = 0; n < 40; n++) begin
            int l2, l16, t;
            logic [17:0] got2, got16;
            sel2 = 5'(n);
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            if (n % 10 == 1) begin ra = 16'h8000; rb = 16'h0000; rbin = 1'b1; end
            if (n % 10 == 2) begin ra = 16'h7FFF; rb = 16'hFFFF; rbin = 1'b0; end
            @(negedge clk);
            bus2.a = sel2[4:3]; bus2.b = sel2[2:1]; bus2.bin = sel2[0];
            bus16.a = ra; bus16.b = rb; bus16.bin = rbin;
            bus2.start = 1'b1; bus16.start = 1'b1;
            @(posedge clk);
            #1;
            bus2.start = 1'b0; bus16.start = 1'b0;
            l2 = 0; l16 = 0; t = 0; got2 = '0; got16 = '0;
            while ((l2 == 0 || l16 == 0) && t < 40) begin
                @(negedge clk);
                t++;
                if (bus2.done && l2 == 0) begin
                    l2 = t; got2 = {bus2.ov, bus2.bo, 14'h0, bus2.di};
                end
                if (bus16.done && l16 == 0) begin
                    l16 = t; got16 = {bus16.ov, bus16.bo, bus16.di};
                end
            end
            chk("w2_latency", l2, 3);
            chk("w2_result", 32'(got2), 32'(ref_sub(2, {14'h0, sel2[4:3]}, {14'h0, sel2[2:1]}, sel2[0])));
            chk("w16_latency", l16, 17);
            chk("w16_result", 32'(got16), 32'(ref_sub(16, ra, rb, rbin)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor, the multi-bit sequential successor to the single-bit half subtractor. It computes `di = a - b - bin` over `WIDTH` operands, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It uses a start/busy/done handshake and reports the final borrow and the signed overflow. It sits beside the combinational arithmetic cells as the area-minimal option for wide operands.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are 2 and above.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: request a subtraction; sampled only in IDLE or DONE.
- `a` input WIDTH: minuend; captured on an accepted start.
- `b` input WIDTH: subtrahend; captured on an accepted start.
- `bin` input 1: borrow-in; captured on an accepted start.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when the result is valid.
- `di` output WIDTH: difference, registered.
- `bo` output 1: final borrow-out, registered.
- `ov` output 1: two's-complement signed overflow, registered.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `busy` = 0, `done` = 0, `di` = 0, `bo` = 0, `ov` = 0. The bit counter, operand shift registers and borrow register are also cleared.
- IDLE or DONE with `start` = 1, start accepted:
  - Latch `a` and `b` into shift registers and load the borrow register with `bin`.
  - Clear the counter to 0 and go to RUN.
  - `di`, `bo` and `ov` keep their previous values until the new result completes.
- IDLE or DONE with `start` = 0: DONE returns to IDLE after one cycle; IDLE stays in IDLE.
- RUN, each cycle, with the current LSBs `x` and `y` and current borrow `c`:
  - Difference bit `d = x ^ y ^ c`; it is shifted into the result register from the MSB end.
  - Next borrow is `(~x & y) | (~(x ^ y) & c)`.
  - Operand registers shift right by one; the counter increments.
- RUN, at counter = `WIDTH-1`, after that bit is processed:
  - Update `di` with the completed result.
  - `bo` takes the final borrow.
  - `ov = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ di[WIDTH-1])`, using the latched operands and the new `di`.
  - Go to DONE.
- `start` during RUN is ignored; the operation is neither restarted nor queued.
- Input changes on `a`, `b` and `bin` after acceptance have no effect.
- Arithmetic: the result is modulo 2^WIDTH. `bo` = 1 exactly when the unsigned value `a` < `b + bin`.
- Reset mid-RUN abandons the operation: next cycle is IDLE with all outputs 0 and no `done` pulse.

## Timing
- Start accepted at rising edge k. `busy` = 1 from edge k through edge k+WIDTH-1.
- Final bit processed at edge k+WIDTH. `done` = 1, and `di`, `bo` and `ov` are valid, for the cycle following edge k+WIDTH.
- Latency is WIDTH+1 cycles from start sample to the `done` cycle. Throughput is one operation per WIDTH+1 cycles.
- Back-to-back operation: `start` = 1 during the `done` cycle is accepted. RUN begins next cycle with no IDLE gap, and `done` is still a single pulse.
- `busy` and `done` are never high together.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `rst` has priority over `start` in the same cycle.

## Test plan
- WIDTH=8, `a`=0x05, `b`=0x03, `bin`=0 -> `done` 9 cycles after start; `di`=0x02, `bo`=0, `ov`=0.
- `a`=0x03, `b`=0x05, `bin`=0 -> `di`=0xFE, `bo`=1, `ov`=0.
- `a`=0x80, `b`=0x01 -> `di`=0x7F, `bo`=0, `ov`=1. Then `a`=0x7F, `b`=0xFF -> `di`=0x80, `bo`=1, `ov`=1.
- `a`=0x00, `b`=0x00, `bin`=1 -> `di`=0xFF, `bo`=1, `ov`=0. Then `a`=0xFF, `b`=0xFF, `bin`=0 -> `di`=0x00, `bo`=0.
- Pulse `start` with new operands mid-RUN -> the result matches the first operands and only one `done` pulse occurs. `start` held high on the `done` cycle -> the second result arrives WIDTH+1 cycles later.
- Assert `rst` at RUN cycle 4 -> next cycle `busy`=0, `done`=0, `di`=0, `bo`=0, `ov`=0, and no `done` pulse follows. Repeat the checks with WIDTH=2 and WIDTH=16 using exhaustive or random operands against a reference model.
